muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage of the MIPS core, next to the ALU. It takes the same two register-file operands and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO feed the write-back mux for MFHI/MFLO, and the control unit stalls the core while `o_busy` is high.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_div_step.sv | 22 ++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and constants shared by the mul/div unit.
// The divide-by-zero LO fill is sliced to WIDTH by the users (WIDTH <= 64).
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    localparam logic [63:0] MD_DZ_LO = '1;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute stage and muldiv_unit.
// master drives the request side, slave is the unit owning HI/LO.
interface muldiv_if #(
    parameter int WIDTH = 32
);

    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_op1, i_op2,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_op1, i_op2,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step on magnitudes.
// Shifts the next dividend bit into the remainder and subtracts if it fits.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    // MSB of the difference is the borrow: set means the divisor did not fit
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owns HI/LO.
// Define MULDIV_DIV_EN to compile in the divider; otherwise DIV/DIVU are no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    muldiv_if.slave  md
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               sgn_a_q, sgn_b_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic             is_mul, is_div;
    logic             neg1, neg2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             go, mt_hi, mt_lo, fin;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_s;
    logic               res_wr, res_dbz;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_mul = (md.i_op == MD_MULT) || (md.i_op == MD_MULTU);
    assign is_div = (md.i_op == MD_DIV) || (md.i_op == MD_DIVU);
    assign neg1   = md_is_signed(md.i_op) & md.i_op1[WIDTH-1];
    assign neg2   = md_is_signed(md.i_op) & md.i_op2[WIDTH-1];
    assign mag1   = neg1 ? -md.i_op1 : md.i_op1;
    assign mag2   = neg2 ? -md.i_op2 : md.i_op2;

    // Shift-add: add multiplicand to the upper half when the low bit is set
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_s   = (sgn_a_q ^ sgn_b_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_s, rem_s;

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .bit_in  (acc_q[WIDTH-1]),
        .divisor (mag_b_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign quo_s = (sgn_a_q ^ sgn_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s = sgn_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign acc_d = div_q ? {rem_next, acc_q[WIDTH-2:0], q_bit} : mul_next;

    // Divisor magnitude is only needed by the divide step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) mag_b_q <= '0;
        else if (go) mag_b_q <= mag2;
    end
`else
    assign acc_d = mul_next;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // Next state and one-cycle control strobes
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (md.i_start) begin
                    unique case (1'b1)
                        is_mul: begin
                            state_d = ST_RUN;
                            go      = 1'b1;
                        end
                        is_div: begin
`ifdef MULDIV_DIV_EN
                            state_d = ST_RUN;
`else
                            state_d = ST_FIN;
`endif
                            go      = 1'b1;
                        end
                        (md.i_op == MD_MTHI): mt_hi = 1'b1;
                        (md.i_op == MD_MTLO): mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                fin     = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sign-corrected result selection for the FIN write
    always_comb begin
        res_wr  = 1'b1;
        res_dbz = 1'b0;
        res_hi  = prod_s[2*WIDTH-1:WIDTH];
        res_lo  = prod_s[WIDTH-1:0];
        if (div_q) begin
`ifdef MULDIV_DIV_EN
            if (mag_b_q == '0) begin
                res_hi  = sgn_a_q ? -mag_a_q : mag_a_q;
                res_lo  = MD_DZ_LO[WIDTH-1:0];
                res_dbz = 1'b1;
            end else begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
`else
            res_wr = 1'b0;
`endif
        end
    end

    // Operand latch, iteration datapath and architectural HI/LO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            mag_a_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= fin;
            if (go) begin
                cnt_q   <= '0;
                div_q   <= is_div;
                sgn_a_q <= neg1;
                sgn_b_q <= neg2;
                mag_a_q <= mag1;
                acc_q   <= {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_d;
            end
            if (mt_hi) hi_q <= md.i_op1;
            if (mt_lo) lo_q <= md.i_op1;
            if (fin) begin
                dbz_q <= res_dbz;
                if (res_wr) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end

    assign md.o_busy        = (state_q != ST_IDLE);
    assign md.o_done        = done_q;
    assign md.o_div_by_zero = dbz_q;
    assign md.o_hi          = hi_q;
    assign md.o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit (WIDTH=32).
// Expectations for DIV/DIVU follow MULDIV_DIV_EN, matching the build under test.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic m_dbz = 1'b0;
    exp_t sb[$];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .md      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issue a MULT/DIV, push its expectation, wait for done, pop and compare
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int elat, input bit inject);
        exp_t e;
        int lat;
        int busy_cnt;
        bit got;
        e.tag = tag; e.hi = eh; e.lo = el; e.dbz = edz; e.lat = elat;
        sb.push_back(e);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_op1   = a;
        bus.i_op2   = b;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_op1   = $urandom;
        bus.i_op2   = $urandom;
        busy_cnt = bus.o_busy ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (lat < 60 && !got) begin
            if (inject && lat == 9) begin
                bus.i_start = 1'b1;
                bus.i_op    = MD_MTLO;
                bus.i_op1   = 32'hDEAD_0000;
                bus.i_op2   = 32'h0000_0001;
            end else if (inject && lat == 10) begin
                bus.i_start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (bus.o_done) got = 1'b1;
            else if (bus.o_busy) busy_cnt++;
        end
        e = sb.pop_front();
        if (!got) begin
            check({e.tag, "_timeout"}, 32'(lat), 32'(e.lat));
        end else begin
            check({e.tag, "_hi"}, bus.o_hi, e.hi);
            check({e.tag, "_lo"}, bus.o_lo, e.lo);
            check({e.tag, "_dbz"}, 32'(bus.o_div_by_zero), 32'(e.dbz));
            check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
            check({e.tag, "_busy"}, 32'(busy_cnt), 32'(e.lat));
            check({e.tag, "_busyfall"}, 32'(bus.o_busy), 32'd0);
        end
        m_hi  = eh;
        m_lo  = el;
        m_dbz = edz;
    endtask

    // DIV/DIVU: full result with the divider, otherwise a one-cycle no-op
    task automatic run_div(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el,
                           input logic edz);
        if (DIV_EN) run_op(tag, op, a, b, eh, el, edz, 33, 1'b0);
        else run_op(tag, op, a, b, m_hi, m_lo, 1'b0, 1, 1'b0);
    endtask

    task automatic mt(input string tag, input logic [2:0] op,
                      input logic [31:0] val);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_op1   = val;
        bus.i_op2   = ~val;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        if (op == MD_MTHI) m_hi = val;
        else m_lo = val;
        check({tag, "_hi"}, bus.o_hi, m_hi);
        check({tag, "_lo"}, bus.o_lo, m_lo);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_dbz"}, 32'(bus.o_div_by_zero), 32'(m_dbz));
    endtask

    initial begin
        int dn;
        bus.i_start = 1'b0;
        bus.i_op    = '0;
        bus.i_op1   = '0;
        bus.i_op2   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.o_hi, 32'd0);
        check("rst_lo", bus.o_lo, 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_dbz", 32'(bus.o_div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult_m1x2", MD_MULT, 32'hFFFF_FFFF, 32'h2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
        run_op("multu_m1x2", MD_MULTU, 32'hFFFF_FFFF, 32'h2,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
        run_op("mult_neg100x7", MD_MULT, 32'hFFFF_FF9C, 32'h7,
               32'hFFFF_FFFF, 32'hFFFF_FD44, 1'b0, 33, 1'b0);
        run_op("mult_min_sq", MD_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 1'b0, 33, 1'b0);

        run_div("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'h2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_div("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h8000_0000, 1'b0);
        run_div("div_100_m7", MD_DIV, 32'h0000_0064, 32'hFFFF_FFF9,
                32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
        run_div("divu_max_16", MD_DIVU, 32'hFFFF_FFFF, 32'h10,
                32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run_div("divu_7_0", MD_DIVU, 32'h7, 32'h0,
                32'h0000_0007, 32'hFFFF_FFFF, 1'b1);

        mt("mtlo_cafe", MD_MTLO, 32'h0000_CAFE);

        run_op("multu_3x5_ign", MD_MULTU, 32'h3, 32'h5,
               32'h0, 32'd15, 1'b0, 33, 1'b1);
        mt("mthi_1234", MD_MTHI, 32'h0000_1234);

        bus.i_start = 1'b1;
        bus.i_op    = 3'b111;
        bus.i_op1   = 32'hFFFF_0000;
        @(posedge clk); #1;
        bus.i_op    = 3'b110;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("undef_busy", 32'(bus.o_busy), 32'd0);
        check("undef_hi", bus.o_hi, m_hi);
        check("undef_lo", bus.o_lo, m_lo);

        bus.i_start = 1'b1;
        bus.i_op    = MD_MULT;
        bus.i_op1   = 32'hFFFF_FFFF;
        bus.i_op2   = 32'h2;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.o_hi, 32'd0);
        check("midrst_lo", bus.o_lo, 32'd0);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_done", 32'(bus.o_done), 32'd0);
        check("midrst_dbz", 32'(bus.o_div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.o_done || bus.o_busy) dn++;
        end
        check("midrst_quiet", 32'(dn), 32'd0);
        m_hi  = '0;
        m_lo  = '0;
        m_dbz = 1'b0;

        run_op("multu_max_sq", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0);
        run_op("multu_2p32", MD_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'h0000_0001, 32'h0000_0000, 1'b0, 33, 1'b0);

        @(posedge clk); #1;
        check("end_done_low", 32'(bus.o_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
